// File: rtl/timer_control.sv
// Egg-timer control: edge-detects debounced buttons, edits mm:ss, counts down
// on a 1 Hz tick and holds a time-limited alarm at 00:00.
module timer_control #(
  parameter int unsigned MAX_MIN     = 99,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned MIN_W  = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned ACNT_W = $clog2(ALARM_TICKS + 1);
  localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(59);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [MIN_W-1:0]  min_d;
  logic [SEC_W-1:0]  sec_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;

  logic prev_start, prev_min, prev_sec, prev_clear;
  logic press_start_c, press_min_c, press_sec_c, press_clear_c;
  logic time_zero_c;
  logic [MIN_W-1:0] min_inc_c;
  logic [SEC_W-1:0] sec_inc_c;

  // Rising-edge press events; prev regs reset high so a held button is silent.
  assign press_start_c = btn_start & ~prev_start;
  assign press_min_c   = btn_min   & ~prev_min;
  assign press_sec_c   = btn_sec   & ~prev_sec;
  assign press_clear_c = btn_clear & ~prev_clear;

  assign time_zero_c = (minutes == '0) && (seconds == '0);
  assign min_inc_c   = (minutes == MIN_LAST) ? '0 : minutes + MIN_W'(1);
  assign sec_inc_c   = (seconds == SEC_LAST) ? '0 : seconds + SEC_W'(1);

  // State, time and alarm counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      minutes    <= '0;
      seconds    <= '0;
      acnt_q     <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      prev_start <= 1'b1;
      prev_min   <= 1'b1;
      prev_sec   <= 1'b1;
      prev_clear <= 1'b1;
    end else begin
      state_q    <= state_d;
      minutes    <= min_d;
      seconds    <= sec_d;
      acnt_q     <= acnt_d;
      running    <= (state_d == S_RUN);
      alarm      <= (state_d == S_ALARM);
      prev_start <= btn_start;
      prev_min   <= btn_min;
      prev_sec   <= btn_sec;
      prev_clear <= btn_clear;
    end
  end

  // Next-state and next-time logic; priority clear > start > edits > tick.
  always_comb begin
    state_d = state_q;
    min_d   = minutes;
    sec_d   = seconds;
    acnt_d  = acnt_q;

    if (press_clear_c) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
      acnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (press_start_c) begin
            if (!time_zero_c) state_d = S_RUN;
          end else begin
            if (press_min_c) min_d = min_inc_c;
            if (press_sec_c) sec_d = sec_inc_c;
          end
        end

        S_RUN: begin
          if (press_start_c) begin
            state_d = S_PAUSE;
          end else if (tick_1hz) begin
            if (seconds != '0) begin
              sec_d = seconds - SEC_W'(1);
            end else begin
              min_d = minutes - MIN_W'(1);
              sec_d = SEC_LAST;
            end
            if ((min_d == '0) && (sec_d == '0)) begin
              state_d = S_ALARM;
              acnt_d  = '0;
            end
          end
        end

        S_PAUSE: begin
          if (press_start_c) begin
            state_d = time_zero_c ? S_IDLE : S_RUN;
          end else begin
            if (press_min_c) min_d = min_inc_c;
            if (press_sec_c) sec_d = sec_inc_c;
          end
        end

        S_ALARM: begin
          min_d = '0;
          sec_d = '0;
          if (press_start_c) begin
            state_d = S_IDLE;
            acnt_d  = '0;
          end else if (tick_1hz) begin
            if (acnt_q + ACNT_W'(1) == ALARM_LAST) begin
              state_d = S_IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + ACNT_W'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control: editing, countdown, pause, alarm, clear, reset.
module tb_timer_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic       btn_clear = 1'b0;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       alarm;

  int pass_cnt = 0;
  int total_cnt = 0;

  timer_control #(.MAX_MIN(99), .ALARM_TICKS(10)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_start(btn_start), .btn_min(btn_min), .btn_sec(btn_sec), .btn_clear(btn_clear),
    .minutes(minutes), .seconds(seconds), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin btn_min = 1'b1; step(); btn_min = 1'b0; step(); end
  endtask

  task automatic press_sec(input int n);
    for (int i = 0; i < n; i++) begin btn_sec = 1'b1; step(); btn_sec = 1'b0; step(); end
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(); btn_start = 1'b0; step();
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; step(); btn_clear = 1'b0; step();
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== 15'd0)
      $display("FAIL reset_outputs: got min=%0d sec=%0d run=%b alm=%b, want all 0",
               minutes, seconds, running, alarm);
    else pass_cnt++;
  endtask

  task automatic test_set_time();
    press_min(2); press_sec(3);
    total_cnt++;
    if (minutes !== 7'd2) $display("FAIL set_min: got %0d want 2", minutes); else pass_cnt++;
    total_cnt++;
    if (seconds !== 6'd3) $display("FAIL set_sec: got %0d want 3", seconds); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL set_idle_running: got %b want 0", running); else pass_cnt++;
  endtask

  task automatic test_countdown_alarm();
    press_clear(); press_sec(2); press_start();
    total_cnt++;
    if (running !== 1'b1) $display("FAIL cd_start: running=%b want 1", running); else pass_cnt++;
    do_tick();
    total_cnt++;
    if ({minutes, seconds, running} !== {7'd0, 6'd1, 1'b1})
      $display("FAIL cd_tick1: got %0d:%0d run=%b want 0:1 run=1", minutes, seconds, running);
    else pass_cnt++;
    do_tick();
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== {7'd0, 6'd0, 1'b0, 1'b1})
      $display("FAIL cd_alarm: got %0d:%0d run=%b alm=%b want 0:0 run=0 alm=1",
               minutes, seconds, running, alarm);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) begin do_tick(); step(); end
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL alarm_9_ticks: alarm=%b want 1", alarm); else pass_cnt++;
    do_tick();
    total_cnt++;
    if ({running, alarm} !== 2'b00)
      $display("FAIL alarm_10_ticks: run=%b alm=%b want 0 0", running, alarm);
    else pass_cnt++;
  endtask

  task automatic test_pause_edit();
    press_clear(); press_min(1); press_start();
    do_tick();
    total_cnt++;
    if ({minutes, seconds} !== {7'd0, 6'd59})
      $display("FAIL run_borrow: got %0d:%0d want 0:59", minutes, seconds);
    else pass_cnt++;
    btn_start = 1'b1; tick_1hz = 1'b1; step(); btn_start = 1'b0; tick_1hz = 1'b0;
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== {7'd0, 6'd59, 1'b0, 1'b0})
      $display("FAIL pause_on_tick: got %0d:%0d run=%b alm=%b want 0:59 run=0 alm=0",
               minutes, seconds, running, alarm);
    else pass_cnt++;
    step(); do_tick(); step();
    total_cnt++;
    if (seconds !== 6'd59) $display("FAIL pause_ignores_tick: sec=%0d want 59", seconds); else pass_cnt++;
    press_sec(1);
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== {7'd0, 6'd0, 1'b0, 1'b0})
      $display("FAIL pause_sec_wrap: got %0d:%0d run=%b alm=%b want 0:0 run=0 alm=0",
               minutes, seconds, running, alarm);
    else pass_cnt++;
    // Start at 00:00 in PAUSE goes to IDLE; a later sec edit then start must run.
    press_start();
    total_cnt++;
    if (running !== 1'b0) $display("FAIL pause_zero_start: running=%b want 0", running); else pass_cnt++;
    press_sec(1); press_start();
    total_cnt++;
    if (running !== 1'b1) $display("FAIL idle_after_pause: running=%b want 1", running); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    press_clear(); press_start();
    total_cnt++;
    if ({minutes, seconds, running} !== 14'd0)
      $display("FAIL start_at_zero: got %0d:%0d run=%b want 0:0 run=0", minutes, seconds, running);
    else pass_cnt++;
    press_min(99);
    total_cnt++;
    if (minutes !== 7'd99) $display("FAIL min_max: got %0d want 99", minutes); else pass_cnt++;
    press_min(1);
    total_cnt++;
    if (minutes !== 7'd0) $display("FAIL min_wrap: got %0d want 0", minutes); else pass_cnt++;
    btn_min = 1'b1;
    repeat (100) step();
    btn_min = 1'b0; step();
    total_cnt++;
    if (minutes !== 7'd1) $display("FAIL held_once: got %0d want 1", minutes); else pass_cnt++;
    btn_sec = 1'b1; reset = 1'b1; step(); reset = 1'b0;
    repeat (3) step();
    btn_sec = 1'b0; step();
    total_cnt++;
    if ({minutes, seconds} !== 13'd0)
      $display("FAIL held_through_reset: got %0d:%0d want 0:0", minutes, seconds);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    press_clear();
    btn_min = 1'b1; btn_sec = 1'b1; step(); btn_min = 1'b0; btn_sec = 1'b0; step();
    total_cnt++;
    if ({minutes, seconds} !== {7'd1, 6'd1})
      $display("FAIL min_sec_same_cycle: got %0d:%0d want 1:1", minutes, seconds);
    else pass_cnt++;
    btn_min = 1'b1; step(); btn_min = 1'b0; step(); btn_min = 1'b1; step(); btn_min = 1'b0; step();
    total_cnt++;
    if (minutes !== 7'd3) $display("FAIL repress_gap1: got %0d want 3", minutes); else pass_cnt++;
  endtask

  task automatic test_clear();
    press_clear(); press_min(3); press_sec(15); press_start();
    btn_clear = 1'b1; tick_1hz = 1'b1; step(); btn_clear = 1'b0; tick_1hz = 1'b0;
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== 15'd0)
      $display("FAIL clear_vs_tick: got %0d:%0d run=%b alm=%b want 0:0 run=0 alm=0",
               minutes, seconds, running, alarm);
    else pass_cnt++;
    step(); press_sec(1); press_start(); do_tick();
    total_cnt++;
    if (alarm !== 1'b1) $display("FAIL alarm_entry: alarm=%b want 1", alarm); else pass_cnt++;
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
    total_cnt++;
    if ({running, alarm} !== 2'b00)
      $display("FAIL clear_in_alarm: run=%b alm=%b want 0 0", running, alarm);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_in_run();
    press_clear(); press_min(5); press_start();
    total_cnt++;
    if ({minutes, seconds, running} !== {7'd5, 6'd0, 1'b1})
      $display("FAIL run_at_5min: got %0d:%0d run=%b want 5:0 run=1", minutes, seconds, running);
    else pass_cnt++;
    reset = 1'b1; tick_1hz = 1'b1; btn_start = 1'b1; step();
    total_cnt++;
    if ({minutes, seconds, running, alarm} !== 15'd0)
      $display("FAIL reset_in_run: got %0d:%0d run=%b alm=%b want all 0",
               minutes, seconds, running, alarm);
    else pass_cnt++;
    reset = 1'b0; tick_1hz = 1'b0; step(); btn_start = 1'b0; step();
    total_cnt++;
    if (running !== 1'b0) $display("FAIL post_reset_idle: running=%b want 0", running); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_countdown_alarm();
    test_pause_edit();
    test_boundaries();
    test_back_to_back();
    test_clear();
    test_reset_in_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Exclusivity of running and alarm, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && running && alarm) begin
      total_cnt++;
      $display("FAIL run_alarm_exclusive: running=%b alarm=%b want not both 1", running, alarm);
    end
  end

endmodule
